// File: rtl/updown_seq_pkg.sv
// Shared types and constants for the up/down counter sequencer.
package updown_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Phase value doubles as the step direction it implies.
  typedef enum logic {
    PH_UP   = 1'b0,
    PH_DOWN = 1'b1
  } phase_t;

endpackage

// File: rtl/updown_counter_core.sv
// WIDTH-bit modulo up/down counter; clear wins over enable.
module updown_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= dir ? count - 1'b1 : count + 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter_sequencer.sv
// Command-driven sequencer: accepts a run command and paces counter steps
// with a reloading prescaler until the end value is reached.
//   state   | meaning
//   IDLE    | cmd_ready high, clr honoured, waiting for a command
//   RUN     | prescaler counting, counter stepping on each slot
//   DONE    | one-cycle done pulse, then back to IDLE
module updown_counter_sequencer
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [PER_W-1:0] cmd_period,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  phase_t           phase;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] target_q;
  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] presc;
  logic             dir_q;
  logic             err_q;

  logic             accept;
  logic             clr_now;
  logic [WIDTH-1:0] start_cnt;
  logic             start_at_tgt;
  logic             slot;
  logic             step_dir;
  logic             step_en;
  logic [WIDTH-1:0] next_cnt;
  logic             bounce_turn;
  logic             run_end;

  assign accept       = cmd_valid && (state == ST_IDLE);
  assign clr_now      = clr && (state == ST_IDLE);
  // A same-edge clear is applied before the accept compare.
  assign start_cnt    = clr_now ? '0 : count;
  assign start_at_tgt = (start_cnt == cmd_target);
  assign slot         = (state == ST_RUN) && !abort && (presc == '0);

  always_comb begin
    step_dir    = 1'b0;
    step_en     = 1'b0;
    bounce_turn = 1'b0;
    run_end     = 1'b0;
    case (mode_q)
      MODE_UP:     step_dir = 1'b0;
      MODE_DOWN:   step_dir = 1'b1;
      MODE_BOUNCE: step_dir = (phase == PH_DOWN);
      default:     step_dir = 1'b0;
    endcase
    next_cnt = step_dir ? count - 1'b1 : count + 1'b1;
    if (slot) begin
      case (mode_q)
        MODE_UP, MODE_DOWN: begin
          step_en = 1'b1;
          run_end = (next_cnt == target_q);
        end
        MODE_BOUNCE: begin
          if (phase == PH_UP) begin
            step_en     = 1'b1;
            bounce_turn = (next_cnt == target_q);
          end else begin
            // Phase 2 that begins at zero finishes without stepping.
            step_en = (count != '0);
            run_end = (count == '0) || (next_cnt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      phase    <= PH_UP;
      mode_q   <= MODE_UP;
      target_q <= '0;
      period_q <= '0;
      presc    <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mode_q   <= cmd_mode;
            target_q <= cmd_target;
            period_q <= cmd_period;
            presc    <= cmd_period;
            if (cmd_mode == MODE_RSVD) begin
              err_q <= 1'b1;
            end else if (cmd_mode != MODE_BOUNCE && start_at_tgt) begin
              state <= ST_DONE;
              dir_q <= (cmd_mode == MODE_DOWN);
            end else begin
              state <= ST_RUN;
              dir_q <= (cmd_mode == MODE_DOWN) ||
                       (cmd_mode == MODE_BOUNCE && start_at_tgt);
              phase <= (cmd_mode == MODE_BOUNCE && start_at_tgt) ? PH_DOWN : PH_UP;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (presc == '0) begin
            presc <= period_q;
            if (step_en)     dir_q <= step_dir;
            if (bounce_turn) phase <= PH_DOWN;
            if (run_end)     state <= ST_DONE;
          end else begin
            presc <= presc - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (step_en),
    .dir     (step_dir),
    .clr     (clr_now),
    .count   (count)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign dir       = dir_q;
  assign err       = err_q;

endmodule

// File: tb/tb_updown_counter_sequencer.sv
// Directed bench for updown_counter_sequencer with hand-computed expectations.
module tb_updown_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_target = 4'd0;
  logic [7:0] cmd_period = 8'd0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       dir;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int failures = 0;

  updown_counter_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr        (clr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_target (cmd_target),
    .cmd_period (cmd_period),
    .abort      (abort),
    .count      (count),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic [3:0] t, input logic [7:0] p);
    cmd_valid  = 1'b1;
    cmd_mode   = m;
    cmd_target = t;
    cmd_period = p;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL %s_timeout cmd_ready=%0b required=1", name, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({count, dir, cmd_ready, busy, done, err} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state count=%0d dir=%0b rdy=%0b busy=%0b done=%0b err=%0b required 0,0,1,0,0,0",
               count, dir, cmd_ready, busy, done, err);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_up();
    send(2'b00, 4'd5, 8'd0);
    checks++;
    if (busy !== 1'b1 || count !== 4'd0) begin
      failures++;
      $display("FAIL up_start busy=%0b count=%0d required 1,0", busy, count);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (count !== 4'(i) || dir !== 1'b0) begin
        failures++;
        $display("FAIL up_step%0d count=%0d dir=%0b required %0d,0", i, count, dir, i);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL up_done done=%0b busy=%0b required 1,0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || count !== 4'd5) begin
      failures++;
      $display("FAIL up_after done=%0b busy=%0b rdy=%0b count=%0d required 0,0,1,5",
               done, busy, cmd_ready, count);
    end
  endtask

  task automatic test_zero_step_and_rsvd();
    send(2'b00, 4'd7, 8'd0);
    wait_idle("to7");
    send(2'b00, 4'd7, 8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd7) begin
      failures++;
      $display("FAIL zero_step done=%0b busy=%0b count=%0d required 1,0,7", done, busy, count);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_step_after done=%0b rdy=%0b required 0,1", done, cmd_ready);
    end
    send(2'b11, 4'd0, 8'd0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || count !== 4'd7) begin
      failures++;
      $display("FAIL rsvd err=%0b busy=%0b rdy=%0b count=%0d required 1,0,1,7",
               err, busy, cmd_ready, count);
    end
    tick();
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rsvd_after err=%0b busy=%0b done=%0b required 0,0,0", err, busy, done);
    end
  endtask

  task automatic test_clr_accept();
    send(2'b00, 4'd9, 8'd0);
    wait_idle("to9");
    checks++;
    if (count !== 4'd9) begin
      failures++;
      $display("FAIL clr_pre count=%0d required 9", count);
    end
    clr = 1'b1;
    send(2'b00, 4'd2, 8'd0);
    clr = 1'b0;
    checks++;
    if (count !== 4'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_accept count=%0d busy=%0b required 0,1", count, busy);
    end
    tick();
    checks++;
    if (count !== 4'd1) begin
      failures++;
      $display("FAIL clr_step1 count=%0d required 1", count);
    end
    tick();
    checks++;
    if (count !== 4'd2 || done !== 1'b1) begin
      failures++;
      $display("FAIL clr_step2 count=%0d done=%0b required 2,1", count, done);
    end
    tick();
  endtask

  task automatic test_down_prescale();
    logic [3:0] exp_c [4] = '{4'd1, 4'd0, 4'd15, 4'd14};
    logic [3:0] prev = 4'd2;
    send(2'b01, 4'd14, 8'd2);
    checks++;
    if (busy !== 1'b1 || dir !== 1'b1 || count !== 4'd2) begin
      failures++;
      $display("FAIL down_start busy=%0b dir=%0b count=%0d required 1,1,2", busy, dir, count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      checks++;
      if (count !== prev) begin
        failures++;
        $display("FAIL down_hold%0d count=%0d required %0d", i, count, prev);
      end
      tick();
      checks++;
      if (count !== exp_c[i] || dir !== 1'b1) begin
        failures++;
        $display("FAIL down_step%0d count=%0d dir=%0b required %0d,1", i, count, dir, exp_c[i]);
      end
      prev = exp_c[i];
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL down_done done=%0b required 1", done);
    end
    tick();
  endtask

  task automatic test_bounce();
    logic [3:0] exp_c [6] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};
    logic       exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      failures++;
      $display("FAIL clr_idle count=%0d required 0", count);
    end
    send(2'b10, 4'd3, 8'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (count !== exp_c[i] || dir !== exp_d[i]) begin
        failures++;
        $display("FAIL bounce_step%0d count=%0d dir=%0b required %0d,%0b",
                 i, count, dir, exp_c[i], exp_d[i]);
      end
      if (i < 5) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL bounce_early_done%0d done=%0b required 0", i, done);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL bounce_done done=%0b required 1", done);
    end
    tick();
  endtask

  task automatic test_abort_and_reset();
    send(2'b00, 4'd9, 8'd0);
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (count !== 4'd4 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre count=%0d busy=%0b required 4,1", count, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (count !== 4'd4 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort count=%0d busy=%0b rdy=%0b done=%0b required 4,0,1,0",
               count, busy, cmd_ready, done);
    end
    tick();
    checks++;
    if (count !== 4'd4 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_after count=%0d done=%0b required 4,0", count, done);
    end
    send(2'b00, 4'd9, 8'd0);
    tick();
    tick();
    checks++;
    if (count !== 4'd6) begin
      failures++;
      $display("FAIL rerun count=%0d required 6", count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d rdy=%0b busy=%0b required 0,1,0", count, cmd_ready, busy);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || cmd_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset count=%0d rdy=%0b done=%0b busy=%0b required 0,1,0,0",
               count, cmd_ready, done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_zero_step_and_rsvd();
    test_clr_accept();
    test_down_prescale();
    test_bounce();
    test_abort_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
